// File: rtl/rv_pkg.sv
// Shared RV32 definitions: opcodes, NOP encoding, fetch FSM states and the
// SB/UJ immediate extractors also used by the decoder.
package rv_pkg;

  localparam logic [6:0]  OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0]  OPCODE_BRANCH   = 7'b1100011;
  localparam logic [31:0] INST_NOP        = 32'h0000_0013;
  localparam int          FETCH_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } fetch_entry_t;

  function automatic logic [31:0] imm_sb(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_uj(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: I-cache port, execute redirect and decode handshake.
// master = fetch unit side, slave = cache/decode/execute environment side.
interface fetch_unit_if;

  logic        icache_ren_o;
  logic [29:0] icache_addr_o;
  logic [31:0] icache_rdata_i;
  logic        icache_stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_stall_i;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        pred_taken_o;

  modport master (
    output icache_ren_o, icache_addr_o, valid_o, inst_o, pc_o, pred_taken_o,
    input  icache_rdata_i, icache_stall_i, redirect_i, redirect_pc_i, id_stall_i
  );

  modport slave (
    input  icache_ren_o, icache_addr_o, valid_o, inst_o, pc_o, pred_taken_o,
    output icache_rdata_i, icache_stall_i, redirect_i, redirect_pc_i, id_stall_i
  );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO of {pc, inst, pred}. Entry 0 is always the head,
// so decode-facing outputs come straight from registers. Flush beats push.
module fetch_buf
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'd0, inst: INST_NOP, pred: 1'b0};

  fetch_entry_t entry_q [FETCH_BUF_DEPTH];
  logic [1:0]   count_reg, count_next;
  logic [1:0]   push_slot;
  logic         do_pop, do_push;

  assign do_pop    = pop && (count_reg != 2'd0);
  assign do_push   = push && ((count_reg != 2'd2) || do_pop);
  // A same-cycle pop shifts entries down first, so the push lands one slot lower.
  assign push_slot = count_reg - {1'b0, do_pop};

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = 2'd0;
    else if (do_push && !do_pop)
      count_next = count_reg + 2'd1;
    else if (do_pop && !do_push)
      count_next = count_reg - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count_reg <= 2'd0;
    else
      count_reg <= count_next;
  end

  for (genvar gi = 0; gi < FETCH_BUF_DEPTH; gi++) begin : g_entry
    fetch_entry_t entry_reg, entry_next, shifted;

    if (gi < FETCH_BUF_DEPTH - 1) begin : g_mid
      assign shifted = entry_q[gi+1];
    end else begin : g_last
      assign shifted = entry_reg;
    end

    always_comb begin
      entry_next = entry_reg;
      if (do_pop)
        entry_next = shifted;
      if (do_push && (push_slot == 2'(gi)))
        entry_next = push_data;
    end

    always_ff @(posedge clk) begin
      if (rst)
        entry_reg <= EMPTY_ENTRY;
      else
        entry_reg <= entry_next;
    end

    assign entry_q[gi] = entry_reg;
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != 2'd0);
  assign head       = entry_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the I-cache, buffers two entries.
// Optional static branch prediction is enabled with `define FETCH_STATIC_PREDICT_EN.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  pending_pc_reg, pending_pc_next;

  logic [1:0]   count;
  logic         head_valid;
  fetch_entry_t head;
  fetch_entry_t push_data;

  logic         ren, capture, push, pop, flush, fills_up;
  logic [31:0]  redirect_pc, seq_pc, next_pc;
  logic         pred;

  assign redirect_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
  assign seq_pc      = pc_reg + 32'd4;

`ifdef FETCH_STATIC_PREDICT_EN
  logic is_jal, is_back_branch;

  assign is_jal         = (bus.icache_rdata_i[6:0] == OPCODE_JAL);
  assign is_back_branch = (bus.icache_rdata_i[6:0] == OPCODE_BRANCH) && bus.icache_rdata_i[31];

  always_comb begin
    next_pc = seq_pc;
    pred    = 1'b0;
    if (is_jal) begin
      next_pc = pc_reg + imm_uj(bus.icache_rdata_i);
      pred    = 1'b1;
    end else if (is_back_branch) begin
      next_pc = pc_reg + imm_sb(bus.icache_rdata_i);
      pred    = 1'b1;
    end
  end
`else
  assign next_pc = seq_pc;
  assign pred    = 1'b0;
`endif

  // KILL keeps the read asserted so the outstanding miss can complete and be dropped.
  assign ren     = !rst && (((state_reg == FETCH) && (count != 2'd2)) || (state_reg == KILL));
  assign capture = ren && !bus.icache_stall_i && (state_reg != KILL);
  assign pop     = head_valid && !bus.id_stall_i;
  assign fills_up = ((count == 2'd2) && !pop) || ((count == 2'd1) && capture && !pop);

  assign push_data = '{pc: pc_reg, inst: bus.icache_rdata_i, pred: pred};

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pending_pc_next = pending_pc_reg;
    push            = 1'b0;
    flush           = 1'b0;
    unique case (state_reg)
      KILL: begin
        if (bus.redirect_i) begin
          flush           = 1'b1;
          pending_pc_next = redirect_pc;
        end
        if (!bus.icache_stall_i) begin
          pc_next    = bus.redirect_i ? redirect_pc : pending_pc_reg;
          state_next = FETCH;
        end
      end
      default: begin
        if (bus.redirect_i) begin
          flush = 1'b1;
          if (ren && bus.icache_stall_i) begin
            pending_pc_next = redirect_pc;
            state_next      = KILL;
          end else begin
            pc_next    = redirect_pc;
            state_next = FETCH;
          end
        end else begin
          if (capture) begin
            push    = 1'b1;
            pc_next = next_pc;
          end
          state_next = fills_up ? HOLD : FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      pending_pc_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pending_pc_reg <= pending_pc_next;
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign bus.icache_ren_o  = ren;
  assign bus.icache_addr_o = pc_reg[31:2];
  assign bus.valid_o       = head_valid;
  assign bus.inst_o        = head_valid ? head.inst : INST_NOP;
  assign bus.pc_o          = head.pc;
  assign bus.pred_taken_o  = head.pred;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed cycle table followed by a randomized run
// checked against an in-order program-stream model.
module tb_fetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] JAL_M8  = {1'b1, 10'h3FC, 1'b1, 8'hFF, 5'd1, 7'b1101111};
  localparam logic [31:0] BEQ_P16 = {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, 7'b1100011};
`ifdef FETCH_STATIC_PREDICT_EN
  localparam bit PREDICT = 1'b1;
`else
  localparam bit PREDICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Program memory: fixed specials at 0x20/0x24, plain ALU ops below 0x1000,
  // a hashed mix of JAL / branches / ALU ops above.
  function automatic logic [31:0] inst_at(input logic [29:0] word);
    logic [31:0] h;
    if (word == 30'h8) return JAL_M8;
    if (word == 30'h9) return BEQ_P16;
    if (word < 30'h400) return {word[19:0], 5'd1, 7'b0010011};
    h = 32'(word) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    case (h[2:0])
      3'd0:    return {h[31:7], 7'b1101111};
      3'd1:    return {1'b1, h[30:7], 7'b1100011};
      3'd2:    return {1'b0, h[30:7], 7'b1100011};
      default: return {h[31:7], 7'b0010011};
    endcase
  endfunction

  always_comb bus.icache_rdata_i = inst_at(bus.icache_addr_o);

  function automatic int uj_off(input logic [31:0] i);
    int v;
    v = i[31] ? -(1 << 20) : 0;
    v += int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    return v;
  endfunction

  function automatic int sb_off(input logic [31:0] i);
    int v;
    v = i[31] ? -4096 : 0;
    v += int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    return v;
  endfunction

  function automatic logic model_pred(input logic [31:0] i);
    if (!PREDICT) return 1'b0;
    return (i[6:0] == 7'b1101111) || ((i[6:0] == 7'b1100011) && i[31]);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] i);
    if (PREDICT && (i[6:0] == 7'b1101111)) return pc + 32'(uj_off(i));
    if (PREDICT && (i[6:0] == 7'b1100011) && i[31]) return pc + 32'(sb_off(i));
    return pc + 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdr;
    logic [31:0] rdr_pc;
    logic        stall;
    logic        id_stall;
    logic        e_ren;
    logic [29:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_pred;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdr, input logic [31:0] rpc, input logic st, input logic ids,
                     input logic ren, input logic [29:0] addr, input logic vld,
                     input logic [31:0] pc, input logic pr);
    vec_t v;
    v = '{rdr, rpc, st, ids, ren, addr, vld, pc, pr};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rdr, input logic [31:0] rpc, input logic st, input logic ids);
    bus.redirect_i     = rdr;
    bus.redirect_pc_i  = rpc;
    bus.icache_stall_i = st;
    bus.id_stall_i     = ids;
  endtask

  logic [31:0] exp_pc;
  logic        prev_redirect, prev_hold;
  logic [29:0] prev_addr;
  int          pops;

  initial begin
    drive(1'b0, 32'd0, 1'b0, 1'b0);

    //   rdr  rdr_pc        st    ids   ren   addr    vld   pc            pred
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h40, 1'b0, 32'h0,    1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h41, 1'b1, 32'h100,  1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h42, 1'b1, 32'h104,  1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 30'h43, 1'b1, 32'h108,  1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 30'h0,  1'b1, 32'h108,  1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 30'h0,  1'b1, 32'h108,  1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 30'h0,  1'b1, 32'h108,  1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 30'h0,  1'b1, 32'h108,  1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h44, 1'b1, 32'h10C,  1'b0);
    add(1'b1, 32'h203,  1'b0, 1'b0, 1'b1, 30'h45, 1'b1, 32'h110,  1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h80, 1'b0, 32'h0,    1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h81, 1'b1, 32'h200,  1'b0);
    add(1'b1, 32'h10C,  1'b0, 1'b0, 1'b1, 30'h82, 1'b1, 32'h204,  1'b0);
    add(1'b1, 32'h400,  1'b1, 1'b0, 1'b1, 30'h43, 1'b0, 32'h0,    1'b0);
    add(1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 30'h43, 1'b0, 32'h0,    1'b0);
    add(1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 30'h43, 1'b0, 32'h0,    1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h43, 1'b0, 32'h0,    1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h100, 1'b0, 32'h0,   1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h101, 1'b1, 32'h400, 1'b0);
    add(1'b1, 32'h20,   1'b0, 1'b0, 1'b1, 30'h102, 1'b1, 32'h404, 1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h08, 1'b0, 32'h0,    1'b0);
    add(1'b1, 32'h24,   1'b0, 1'b0, 1'b1, PREDICT ? 30'h06 : 30'h09, 1'b1, 32'h20, PREDICT);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h09, 1'b0, 32'h0,    1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h0A, 1'b1, 32'h24,   1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 30'h0B, 1'b1, 32'h28,   1'b0);

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #5;
    check("reset_ren",   32'(bus.icache_ren_o), 32'd0);
    check("reset_valid", 32'(bus.valid_o),      32'd0);
    check("reset_inst",  bus.inst_o,            NOP);
    check("reset_pc",    bus.pc_o,              32'd0);
    check("reset_pred",  32'(bus.pred_taken_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cycle table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rdr, tbl[i].rdr_pc, tbl[i].stall, tbl[i].id_stall);
      #4;
      check($sformatf("vec%0d_ren", i), 32'(bus.icache_ren_o), 32'(tbl[i].e_ren));
      if (tbl[i].e_ren)
        check($sformatf("vec%0d_addr", i), 32'(bus.icache_addr_o), 32'(tbl[i].e_addr));
      check($sformatf("vec%0d_valid", i), 32'(bus.valid_o), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        check($sformatf("vec%0d_pc", i), bus.pc_o, tbl[i].e_pc);
        check($sformatf("vec%0d_pred", i), 32'(bus.pred_taken_o), 32'(tbl[i].e_pred));
        check($sformatf("vec%0d_inst", i), bus.inst_o, inst_at(tbl[i].e_pc[31:2]));
      end else begin
        check($sformatf("vec%0d_nop", i), bus.inst_o, NOP);
      end
      @(posedge clk);
      #1;
    end

    // Randomized run against the program-stream model
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc        = 32'h100;
    prev_redirect = 1'b0;
    prev_hold     = 1'b0;
    prev_addr     = '0;
    pops          = 0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 15) == 0,
            32'h1000 + 32'($urandom_range(0, 16383)),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0);
      #4;
      if (!bus.valid_o)
        check("rnd_nop", bus.inst_o, NOP);
      if (prev_redirect)
        check("rnd_valid_after_redirect", 32'(bus.valid_o), 32'd0);
      if (prev_hold) begin
        check("rnd_miss_ren_held", 32'(bus.icache_ren_o), 32'd1);
        check("rnd_miss_addr_held", 32'(bus.icache_addr_o), 32'(prev_addr));
      end
      if (bus.valid_o && !bus.id_stall_i) begin
        check("rnd_pc", bus.pc_o, exp_pc);
        check("rnd_inst", bus.inst_o, inst_at(exp_pc[31:2]));
        check("rnd_pred", 32'(bus.pred_taken_o), 32'(model_pred(inst_at(exp_pc[31:2]))));
        exp_pc = model_next(exp_pc, inst_at(exp_pc[31:2]));
        pops++;
      end
      if (bus.redirect_i)
        exp_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
      prev_redirect = bus.redirect_i;
      prev_hold     = bus.icache_ren_o && bus.icache_stall_i;
      prev_addr     = bus.icache_addr_o;
      @(posedge clk);
      #1;
    end
    check("rnd_progress", 32'(pops > 500), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
